vec_alu_ctrl: RTL

VEC_ALU_CTRL -- requirements
Module: vec_alu_ctrl

---
 rtl/vec_alu_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vec_alu_ctrl.sv
// Controller sequencing an external 16-lane vector ALU over four 512-bit registers.
// Loads and add/mul commands are accepted in IDLE; results are written back after ALU_WAIT cycles.
module vec_alu_ctrl #(
  parameter int ALU_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [1:0]   cmd_rs1,
  input  logic [1:0]   cmd_rs2,
  input  logic [1:0]   cmd_rd,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [1:0]   ld_addr,
  input  logic [511:0] ld_data,
  input  logic [1:0]   rd_addr,
  output logic [511:0] rd_data,
  output logic         alu_se1,
  output logic         alu_se0,
  output logic [511:0] alu_a,
  output logic [511:0] alu_b,
  input  logic [511:0] alu_s0,
  input  logic [511:0] alu_s1,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  logic [1:0]   state_r;
  logic [511:0] vreg_r [4];
  logic [3:0]   cnt_r;
  logic [1:0]   rd_r;
  logic [1:0]   op_r;
  logic         se1_r;
  logic         se0_r;
  logic         busy_r;
  logic         done_r;
  logic         err_r;
  logic [511:0] alu_a_r;
  logic [511:0] alu_b_r;

  logic         ld_fire_s;
  logic         cmd_fire_s;
  logic [1:0]   rd_hi_s;

  // A pending load takes priority, so the command handshake is masked while ld_valid is high.
  assign ld_ready   = (state_r == S_IDLE);
  assign cmd_ready  = (state_r == S_IDLE) && !ld_valid;
  assign ld_fire_s  = ld_valid && ld_ready;
  assign cmd_fire_s = cmd_valid && cmd_ready;
  assign rd_hi_s    = rd_r + 2'd1;

  assign rd_data = vreg_r[rd_addr];
  assign alu_se1 = se1_r;
  assign alu_se0 = se0_r;
  assign alu_a   = alu_a_r;
  assign alu_b   = alu_b_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

  // Command sequencing, register file writes and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        vreg_r[i] <= 512'd0;
      end
      cnt_r   <= 4'd0;
      rd_r    <= 2'd0;
      op_r    <= 2'd0;
      se1_r   <= 1'b0;
      se0_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      alu_a_r <= 512'd0;
      alu_b_r <= 512'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ld_fire_s) begin
            vreg_r[ld_addr] <= ld_data;
          end
          if (cmd_fire_s) begin
            alu_a_r <= vreg_r[cmd_rs1];
            alu_b_r <= vreg_r[cmd_rs2];
            rd_r    <= cmd_rd;
            op_r    <= cmd_op;
            cnt_r   <= WAIT_INIT;
            se1_r   <= ~cmd_op[1];
            se0_r   <= cmd_op[0];
            busy_r  <= 1'b1;
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          // A count of one marks the final settle cycle: capture on this edge.
          if (cnt_r <= 4'd1) begin
            case (op_r)
              OP_ADD: vreg_r[rd_r] <= alu_s0;
              OP_MUL: begin
                vreg_r[rd_r]    <= alu_s0;
                vreg_r[rd_hi_s] <= alu_s1;
              end
              default: ;
            endcase
            cnt_r   <= 4'd0;
            se1_r   <= 1'b0;
            se0_r   <= 1'b0;
            done_r  <= 1'b1;
            err_r   <= op_r[1];
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          se1_r   <= 1'b0;
          se0_r   <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
